// File: rtl/dram_arbiter.sv
// ============================================================================
// dram_arbiter : two-port round-robin DRAM arbiter (I-cache / D-cache)
// Rev 1.0
// ============================================================================
`default_nettype none

module dram_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_cs,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ack,

    input  logic              req1_cs,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ack,

    output logic [DATA_W-1:0] rdata,

    output logic              dram_cs,
    output logic              dram_we,
    output logic [ADDR_W-1:0] dram_addr,
    output logic [DATA_W-1:0] dram_wdata,
    input  logic [DATA_W-1:0] dram_rdata,
    input  logic              dram_ack,

    output logic              grant0,
    output logic              grant1
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_BUSY0   = 2'd1;
    localparam logic [1:0] c_BUSY1   = 2'd2;
    localparam logic [1:0] c_RELEASE = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              last_q,  last_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic w_busy0;
    logic w_busy1;

    assign w_busy0 = (state_q == c_BUSY0);
    assign w_busy1 = (state_q == c_BUSY1);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        rdata_d = rdata_q;
        case (state_q)
            c_IDLE: begin
                // On a tie, the port that did not win last time goes first.
                if (req0_cs && (!req1_cs || last_q)) begin
                    state_d = c_BUSY0;
                    last_d  = 1'b0;
                end else if (req1_cs) begin
                    state_d = c_BUSY1;
                    last_d  = 1'b1;
                end
            end
            c_BUSY0: begin
                if (!req0_cs) begin
                    state_d = c_RELEASE;
                end else if (dram_ack) begin
                    state_d = c_RELEASE;
                    if (!req0_we) rdata_d = dram_rdata;
                end
            end
            c_BUSY1: begin
                if (!req1_cs) begin
                    state_d = c_RELEASE;
                end else if (dram_ack) begin
                    state_d = c_RELEASE;
                    if (!req1_we) rdata_d = dram_rdata;
                end
            end
            default: state_d = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= c_IDLE;
            last_q  <= 1'b1;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            rdata_q <= rdata_d;
        end
    end

    assign grant0 = w_busy0;
    assign grant1 = w_busy1;

    // Ack is suppressed while reset is low so a reset mid-transfer abandons it silently.
    assign req0_ack = rst & w_busy0 & req0_cs & dram_ack;
    assign req1_ack = rst & w_busy1 & req1_cs & dram_ack;

    assign dram_cs    = (w_busy0 & req0_cs) | (w_busy1 & req1_cs);
    assign dram_we    = w_busy0 ? req0_we    : (w_busy1 ? req1_we    : 1'b0);
    assign dram_addr  = w_busy0 ? req0_addr  : (w_busy1 ? req1_addr  : '0);
    assign dram_wdata = w_busy0 ? req0_wdata : (w_busy1 ? req1_wdata : '0);

    assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_dram_arbiter.sv
// ============================================================================
// tb_dram_arbiter : directed self-checking bench for dram_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_dram_arbiter;

    localparam int AW = 32;
    localparam int DW = 128;

    logic          clk;
    logic          rst;
    logic          req0_cs, req0_we, req0_ack;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;
    logic          req1_cs, req1_we, req1_ack;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;
    logic [DW-1:0] rdata;
    logic          dram_cs, dram_we;
    logic [AW-1:0] dram_addr;
    logic [DW-1:0] dram_wdata;
    logic [DW-1:0] dram_rdata;
    logic          dram_ack;
    logic          grant0, grant1;

    logic [4:0]    ctl;
    int            n_cmp;
    int            n_err;

    assign ctl = {grant0, grant1, dram_cs, req0_ack, req1_ack};

    dram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_cs    (req0_cs),
        .req0_we    (req0_we),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .req0_ack   (req0_ack),
        .req1_cs    (req1_cs),
        .req1_we    (req1_we),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .req1_ack   (req1_ack),
        .rdata      (rdata),
        .dram_cs    (dram_cs),
        .dram_we    (dram_we),
        .dram_addr  (dram_addr),
        .dram_wdata (dram_wdata),
        .dram_rdata (dram_rdata),
        .dram_ack   (dram_ack),
        .grant0     (grant0),
        .grant1     (grant1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req0_cs = 0; req0_we = 0; req0_addr = '0; req0_wdata = '0;
        req1_cs = 0; req1_we = 0; req1_addr = '0; req1_wdata = '0;
        dram_ack = 0; dram_rdata = '0;
    endtask

    task automatic do_reset();
        rst = 0;
        clear_inputs();
        tick();
        rst = 1;
    endtask

    task automatic test_reset();
        rst = 0;
        clear_inputs();
        tick(); tick();
        @(negedge clk);
        if (ctl !== 5'b00000) begin $display("FAIL reset_ctl: got %b expected %b", ctl, 5'b00000); n_err++; end
        n_cmp++;
        if (rdata !== '0) begin $display("FAIL reset_rdata: got %h expected 0", rdata); n_err++; end
        n_cmp++;
        if ({dram_we, dram_addr, dram_wdata} !== '0) begin
            $display("FAIL reset_bus: got we=%b addr=%h wdata=%h expected zeros", dram_we, dram_addr, dram_wdata); n_err++;
        end
        n_cmp++;
        tick();
    endtask

    task automatic test_read();
        do_reset();
        req0_cs = 1; req0_we = 0; req0_addr = 32'h100;
        @(negedge clk);
        if (ctl !== 5'b00000) begin $display("FAIL read_idle: got %b expected %b", ctl, 5'b00000); n_err++; end
        n_cmp++;
        tick();
        @(negedge clk);
        if (ctl !== 5'b10100) begin $display("FAIL read_grant: got %b expected %b", ctl, 5'b10100); n_err++; end
        n_cmp++;
        if (dram_addr !== 32'h100 || dram_we !== 1'b0) begin
            $display("FAIL read_bus: got addr=%h we=%b expected addr=100 we=0", dram_addr, dram_we); n_err++;
        end
        n_cmp++;
        tick();
        @(negedge clk);
        if (ctl !== 5'b10100) begin $display("FAIL read_wait: got %b expected %b", ctl, 5'b10100); n_err++; end
        n_cmp++;
        tick();
        dram_ack = 1; dram_rdata = {16{8'hA5}};
        @(negedge clk);
        if (ctl !== 5'b10110) begin $display("FAIL read_ack: got %b expected %b", ctl, 5'b10110); n_err++; end
        n_cmp++;
        tick();
        dram_ack = 0; dram_rdata = '0; req0_cs = 0;
        @(negedge clk);
        if (ctl !== 5'b00000) begin $display("FAIL read_release: got %b expected %b", ctl, 5'b00000); n_err++; end
        n_cmp++;
        if (rdata !== {16{8'hA5}}) begin $display("FAIL read_rdata: got %h expected %h", rdata, {16{8'hA5}}); n_err++; end
        n_cmp++;
        tick();
    endtask

    task automatic test_tie();
        do_reset();
        req0_addr = 32'h10; req1_addr = 32'h20;
        req0_cs = 1; req1_cs = 1;
        for (int i = 0; i < 4; i++) begin
            logic [4:0]    exp_g;
            logic [4:0]    exp_a;
            logic [AW-1:0] exp_addr;
            exp_g    = (i % 2 == 0) ? 5'b10100 : 5'b01100;
            exp_a    = (i % 2 == 0) ? 5'b10110 : 5'b01101;
            exp_addr = (i % 2 == 0) ? 32'h10 : 32'h20;
            @(negedge clk);
            if (ctl !== 5'b00000) begin $display("FAIL tie_idle[%0d]: got %b expected %b", i, ctl, 5'b00000); n_err++; end
            n_cmp++;
            tick();
            @(negedge clk);
            if (ctl !== exp_g) begin $display("FAIL tie_grant[%0d]: got %b expected %b", i, ctl, exp_g); n_err++; end
            n_cmp++;
            if (dram_addr !== exp_addr) begin $display("FAIL tie_addr[%0d]: got %h expected %h", i, dram_addr, exp_addr); n_err++; end
            n_cmp++;
            tick();
            dram_ack = 1; dram_rdata = DW'(i);
            @(negedge clk);
            if (ctl !== exp_a) begin $display("FAIL tie_ack[%0d]: got %b expected %b", i, ctl, exp_a); n_err++; end
            n_cmp++;
            tick();
            dram_ack = 0;
            @(negedge clk);
            if (ctl !== 5'b00000) begin $display("FAIL tie_release[%0d]: got %b expected %b", i, ctl, 5'b00000); n_err++; end
            n_cmp++;
            tick();
        end
        req0_cs = 0; req1_cs = 0;
        tick();
    endtask

    task automatic test_write_contention();
        do_reset();
        req1_cs = 1; req1_we = 1; req1_addr = 32'h2000; req1_wdata = {8{16'hDEAD}};
        @(negedge clk);
        if (ctl !== 5'b00000) begin $display("FAIL wr_idle: got %b expected %b", ctl, 5'b00000); n_err++; end
        n_cmp++;
        tick();
        @(negedge clk);
        if (ctl !== 5'b01100) begin $display("FAIL wr_grant: got %b expected %b", ctl, 5'b01100); n_err++; end
        n_cmp++;
        if (dram_we !== 1'b1 || dram_addr !== 32'h2000 || dram_wdata !== {8{16'hDEAD}}) begin
            $display("FAIL wr_bus: got we=%b addr=%h wdata=%h expected we=1 addr=2000 wdata=dead..", dram_we, dram_addr, dram_wdata); n_err++;
        end
        n_cmp++;
        tick();
        req0_cs = 1; req0_we = 0; req0_addr = 32'h40;
        @(negedge clk);
        if (ctl !== 5'b01100 || dram_addr !== 32'h2000) begin
            $display("FAIL wr_contend: got ctl=%b addr=%h expected ctl=01100 addr=2000", ctl, dram_addr); n_err++;
        end
        n_cmp++;
        tick();
        dram_ack = 1; dram_rdata = {16{8'h11}};
        @(negedge clk);
        if (ctl !== 5'b01101) begin $display("FAIL wr_ack: got %b expected %b", ctl, 5'b01101); n_err++; end
        n_cmp++;
        tick();
        dram_ack = 0; req1_cs = 0; req1_we = 0;
        @(negedge clk);
        if (ctl !== 5'b00000) begin $display("FAIL wr_release: got %b expected %b", ctl, 5'b00000); n_err++; end
        n_cmp++;
        if (rdata !== '0) begin $display("FAIL wr_rdata_held: got %h expected 0", rdata); n_err++; end
        n_cmp++;
        tick();
        @(negedge clk);
        if (ctl !== 5'b00000) begin $display("FAIL wr_idle2: got %b expected %b", ctl, 5'b00000); n_err++; end
        n_cmp++;
        tick();
        @(negedge clk);
        if (ctl !== 5'b10100 || dram_addr !== 32'h40 || dram_we !== 1'b0) begin
            $display("FAIL wr_late_grant: got ctl=%b addr=%h we=%b expected ctl=10100 addr=40 we=0", ctl, dram_addr, dram_we); n_err++;
        end
        n_cmp++;
        tick();
        dram_ack = 1; dram_rdata = {16{8'h22}};
        @(negedge clk);
        if (ctl !== 5'b10110) begin $display("FAIL wr_late_ack: got %b expected %b", ctl, 5'b10110); n_err++; end
        n_cmp++;
        tick();
        dram_ack = 0; req0_cs = 0;
        @(negedge clk);
        if (rdata !== {16{8'h22}}) begin $display("FAIL wr_late_rdata: got %h expected %h", rdata, {16{8'h22}}); n_err++; end
        n_cmp++;
        tick();
    endtask

    task automatic test_abort();
        do_reset();
        req1_cs = 1; req1_we = 0; req1_addr = 32'h300;
        tick();
        @(negedge clk);
        if (ctl !== 5'b01100) begin $display("FAIL abort_grant: got %b expected %b", ctl, 5'b01100); n_err++; end
        n_cmp++;
        tick();
        req1_cs = 0;
        @(negedge clk);
        if (ctl !== 5'b01000) begin $display("FAIL abort_cs_low: got %b expected %b", ctl, 5'b01000); n_err++; end
        n_cmp++;
        tick();
        dram_ack = 1; dram_rdata = {16{8'hFF}};
        @(negedge clk);
        if (ctl !== 5'b00000) begin $display("FAIL abort_release: got %b expected %b", ctl, 5'b00000); n_err++; end
        n_cmp++;
        tick();
        dram_ack = 0;
        @(negedge clk);
        if (rdata !== '0) begin $display("FAIL abort_rdata: got %h expected 0", rdata); n_err++; end
        n_cmp++;
        tick();
    endtask

    task automatic test_reset_mid();
        req1_cs = 1; req1_we = 0; req1_addr = 32'h500;
        tick();
        @(negedge clk);
        if (ctl !== 5'b01100) begin $display("FAIL rstmid_grant: got %b expected %b", ctl, 5'b01100); n_err++; end
        n_cmp++;
        tick();
        rst = 0; dram_ack = 1; dram_rdata = {16{8'h99}};
        @(negedge clk);
        if (req1_ack !== 1'b0) begin $display("FAIL rstmid_no_ack: got %b expected 0", req1_ack); n_err++; end
        n_cmp++;
        tick();
        rst = 1; dram_ack = 0; req0_cs = 1; req0_we = 0; req0_addr = 32'h600;
        @(negedge clk);
        if (ctl !== 5'b00000 || rdata !== '0 || {dram_we, dram_addr, dram_wdata} !== '0) begin
            $display("FAIL rstmid_idle: got ctl=%b rdata=%h addr=%h expected all zero", ctl, rdata, dram_addr); n_err++;
        end
        n_cmp++;
        tick();
        @(negedge clk);
        if (ctl !== 5'b10100) begin $display("FAIL rstmid_tie_port0: got %b expected %b", ctl, 5'b10100); n_err++; end
        n_cmp++;
        tick();
        dram_ack = 1; dram_rdata = {16{8'h3C}};
        @(negedge clk);
        if (ctl !== 5'b10110) begin $display("FAIL rstmid_ack: got %b expected %b", ctl, 5'b10110); n_err++; end
        n_cmp++;
        tick();
        dram_ack = 0; req0_cs = 0; req1_cs = 0;
        @(negedge clk);
        if (rdata !== {16{8'h3C}}) begin $display("FAIL rstmid_rdata: got %h expected %h", rdata, {16{8'h3C}}); n_err++; end
        n_cmp++;
        tick();
    endtask

    task automatic test_spurious();
        dram_ack = 1; dram_rdata = {16{8'h77}};
        @(negedge clk);
        if (ctl !== 5'b00000) begin $display("FAIL spur_noack: got %b expected %b", ctl, 5'b00000); n_err++; end
        n_cmp++;
        tick();
        dram_ack = 0;
        @(negedge clk);
        if (rdata !== {16{8'h3C}}) begin $display("FAIL spur_rdata: got %h expected %h", rdata, {16{8'h3C}}); n_err++; end
        n_cmp++;
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 0;
        clear_inputs();
        test_reset();
        test_read();
        test_tie();
        test_write_contention();
        test_abort();
        test_reset_mid();
        test_spurious();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
